data_bus_if: RTL and testbench
==============================

DATA_BUS_IF -- requirements
Module: data_bus_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of REQ-state cycles without acknowledge before the access is aborted.
REQ-002 Parameter RDATA_ZERO_ON_ERR, default 1, selects whether mem_rdata_o is forced to 0 after a timeout.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset: synchronous, active-high.
REQ-005 mem_ce_i  in  1  access request from MEM stage.
REQ-006 mem_we_i  in  1  1 = store, 0 = load.
REQ-007 mem_addr_i  in  32  byte address.
REQ-008 mem_sel_i  in  4  byte-lane enables, bit0 = bits 7:0.
REQ-009 mem_data_i  in  32  store data, already lane-replicated.
REQ-010 mem_stall_i  in  1  MEM stage held this cycle (from pipeline control).
REQ-011 flush_i  in  1  exception flush; kills the in-flight instruction.
REQ-012 mem_rdata_o  out  32  load data returned to MEM stage.
REQ-013 stallreq_o  out  1  pipeline stall request to control.
REQ-014 bus_req_o  out  1  external bus request.
REQ-015 bus_we_o  out  1  external write strobe.
REQ-016 bus_addr_o  out  32  word address, {addr[31:2], 2'b00}.
REQ-017 bus_sel_o  out  4  byte lanes.
REQ-018 bus_wdata_o  out  32  write data.
REQ-019 bus_ack_i  in  1  one-cycle acknowledge.
REQ-020 bus_rdata_i  in  32  read data, valid with bus_ack_i.
REQ-021 bus_err_o  out  1  one-cycle pulse on timeout.

Function
REQ-022 The block SHALL implement FSM states IDLE, REQ, DONE and DRAIN.
REQ-023 IDLE with mem_ce_i=1 and flush_i=0: latch we/addr/sel/wdata, assert stallreq_o combinationally in the same cycle, and move to REQ.
REQ-024 REQ: bus_req_o=1 and bus_* driven from the latches; stallreq_o=1; the timeout counter increments each cycle.
REQ-025 REQ with bus_ack_i=1: capture bus_rdata_i (loads only; 0 for stores), clear the counter, move to DONE.
REQ-026 REQ with counter = TIMEOUT_CYCLES-1 and no ack: drop bus_req_o next cycle, pulse bus_err_o, load mem_rdata_o per RDATA_ZERO_ON_ERR, move to DONE.
REQ-027 DONE: stallreq_o=0 and mem_rdata_o = captured data; stay while mem_stall_i=1, return to IDLE when mem_stall_i=0.
REQ-028 DONE never reissues the access, even though mem_ce_i remains 1 while held.
REQ-029 REQ with flush_i=1: move to DRAIN; bus_req_o stays 1 until ack or timeout, and the returned data is discarded.
REQ-030 DRAIN: stallreq_o = mem_ce_i; on ack or timeout go to IDLE; a new mem_ce_i is only accepted from IDLE.
REQ-031 flush_i in DONE: go to IDLE next cycle.
REQ-032 flush_i in IDLE: the request is ignored.
REQ-033 Ack arriving in the same cycle as flush_i: the data is discarded and the next state is IDLE.
REQ-034 bus_ack_i outside REQ/DRAIN SHALL be ignored.
REQ-035 Minimum load latency: request cycle N, bus_req_o high from N+1, ack at N+1 gives stallreq_o low and valid data at N+2.

Reset
REQ-036 On rst: state=IDLE, counter=0, latches=0; all outputs 0, including bus_req_o, stallreq_o, mem_rdata_o and bus_err_o.
REQ-037 rst mid-REQ SHALL drop bus_req_o the following cycle; the bus tolerates abandoned requests on reset.

Structure
REQ-038 State encoding, the bus-width constant and the timeout default SHALL live in the shared defines package with the other pipeline constants.
REQ-039 The timeout counter SHALL be a separate sub-module, bus_timeout_cnt, with clear/enable/expired ports.
REQ-040 The remainder of the block SHALL be a single FSM plus latches.

Verification
REQ-041 Load, addr 0x80000004, sel 1111, ack 2 cycles after bus_req_o -> bus_addr_o=0x80000004, stallreq_o high 3 cycles, mem_rdata_o=bus_rdata_i=0xDEADBEEF in DONE.
REQ-042 Store, addr 0x00000013, sel 1000, data 0x5A5A5A5A -> bus_addr_o=0x00000010, bus_we_o=1, bus_sel_o=1000, single request.
REQ-043 Load held in DONE by mem_stall_i=1 for 4 cycles -> exactly one bus_req_o burst and mem_rdata_o stable for 4 cycles.
REQ-044 No ack, TIMEOUT_CYCLES=8 -> bus_err_o pulses once after 8 REQ cycles, mem_rdata_o=0, FSM returns to IDLE.
REQ-045 flush_i in the 2nd REQ cycle, then a new load presented -> the first access drains on its ack, stallreq_o stays 1, the second request issues afterwards.
REQ-046 rst asserted in REQ -> the next cycle shows bus_req_o=0, stallreq_o=0 and state IDLE.

Source files
------------

// File: rtl/data_bus_if_pkg.sv
// Shared constants for the MEM-stage data bus interface: bus width, timeout default
// and the access FSM state encoding.
package data_bus_if_pkg;

    localparam int BUS_W           = 32;
    localparam int SEL_W           = BUS_W / 8;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } bus_state_e;

    // The bus is word-addressed; byte position is carried by the lane enables.
    function automatic logic [BUS_W-1:0] word_addr(input logic [BUS_W-1:0] addr);
        return addr & ~BUS_W'(3);
    endfunction

endpackage

// File: rtl/data_bus_if_timeout_cnt.sv
// Cycle counter for an outstanding bus access; expired marks the last cycle that
// may still see an acknowledge before the access is abandoned.
module bus_timeout_cnt
    import data_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/data_bus_if.sv
// MEM-stage to external bus bridge: holds the pipeline while a single load/store is
// outstanding, drains flushed accesses and aborts accesses that never acknowledge.
module data_bus_if
    import data_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = TIMEOUT_DEFAULT,
    parameter bit RDATA_ZERO_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ce_i,
    input  logic             mem_we_i,
    input  logic [BUS_W-1:0] mem_addr_i,
    input  logic [SEL_W-1:0] mem_sel_i,
    input  logic [BUS_W-1:0] mem_data_i,
    input  logic             mem_stall_i,
    input  logic             flush_i,
    output logic [BUS_W-1:0] mem_rdata_o,
    output logic             stallreq_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [BUS_W-1:0] bus_addr_o,
    output logic [SEL_W-1:0] bus_sel_o,
    output logic [BUS_W-1:0] bus_wdata_o,
    input  logic             bus_ack_i,
    input  logic [BUS_W-1:0] bus_rdata_i,
    output logic             bus_err_o
);

    bus_state_e       r_state;
    bus_state_e       w_next;
    logic             r_we;
    logic [BUS_W-1:0] r_addr;
    logic [SEL_W-1:0] r_sel;
    logic [BUS_W-1:0] r_wdata;
    logic [BUS_W-1:0] r_rdata;
    logic             r_err;
    logic             w_busy;
    logic             w_accept;
    logic             w_done;
    logic             w_expired;

    assign w_busy   = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign w_accept = (r_state == ST_IDLE) && mem_ce_i && !flush_i;
    // An access finishes on acknowledge or on its final timeout cycle.
    assign w_done   = bus_ack_i || w_expired;

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_busy || bus_ack_i),
        .i_enable (w_busy),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_REQ;
            ST_REQ: begin
                if (flush_i) begin
                    w_next = w_done ? ST_IDLE : ST_DRAIN;
                end else if (w_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE:  if (flush_i || !mem_stall_i) w_next = ST_IDLE;
            ST_DRAIN: if (w_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        bus_req_o  = 1'b0;
        case (r_state)
            ST_IDLE:  stallreq_o = w_accept;
            ST_REQ: begin
                stallreq_o = 1'b1;
                bus_req_o  = 1'b1;
            end
            ST_DRAIN: begin
                stallreq_o = mem_ce_i;
                bus_req_o  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            stallreq_o = 1'b0;
            bus_req_o  = 1'b0;
        end
    end

    // Request latches load only from IDLE, so DRAIN keeps presenting the killed access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_busy && !bus_ack_i && w_expired;
            if (w_accept) begin
                r_we    <= mem_we_i;
                r_addr  <= word_addr(mem_addr_i);
                r_sel   <= mem_sel_i;
                r_wdata <= mem_data_i;
            end
            if (r_state == ST_REQ && !flush_i) begin
                if (bus_ack_i) begin
                    r_rdata <= r_we ? '0 : bus_rdata_i;
                end else if (w_expired) begin
                    r_rdata <= RDATA_ZERO_ON_ERR ? '0 : bus_rdata_i;
                end
            end
        end
    end

    assign mem_rdata_o = r_rdata;
    assign bus_we_o    = r_we && bus_req_o;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;
    assign bus_err_o   = r_err;

endmodule

// File: tb/tb_data_bus_if.sv
// Directed bench for data_bus_if: load/store, DONE hold, timeout, flush/drain and reset.
module tb_data_bus_if;

    logic        clk;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic        mem_stall_i;
    logic        flush_i;
    logic [31:0] mem_rdata_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    data_bus_if #(
        .TIMEOUT_CYCLES   (8),
        .RDATA_ZERO_ON_ERR(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_stall_i(mem_stall_i),
        .flush_i    (flush_i),
        .mem_rdata_o(mem_rdata_o),
        .stallreq_o (stallreq_o),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_sel_o  (bus_sel_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_ack_i  (bus_ack_i),
        .bus_rdata_i(bus_rdata_i),
        .bus_err_o  (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data);
        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        smp();
        total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_req_o); end
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stallreq got=%b exp=0", stallreq_o); end
        total++; if (mem_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", mem_rdata_o); end
        total++; if (bus_err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus_err_o); end
        total++; if (bus_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus_addr_o); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_load();
        int nstall = 0;
        cyc(); set_req(1'b0, 32'h8000_0004, 4'hF, 32'h0); smp();
        nstall += int'(stallreq_o);
        total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL load_req_early got=%b exp=0", bus_req_o); end
        cyc(); smp();
        nstall += int'(stallreq_o);
        total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL load_req got=%b exp=1", bus_req_o); end
        total++; if (bus_addr_o !== 32'h8000_0004) begin bad++; $display("FAIL load_addr got=%h exp=80000004", bus_addr_o); end
        total++; if (bus_we_o !== 1'b0) begin bad++; $display("FAIL load_we got=%b exp=0", bus_we_o); end
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF; smp();
        nstall += int'(stallreq_o);
        total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL load_req2 got=%b exp=1", bus_req_o); end
        cyc(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; smp();
        nstall += int'(stallreq_o);
        total++; if (nstall !== 3) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=3", nstall); end
        total++; if (mem_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", mem_rdata_o); end
        total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL load_req_done got=%b exp=0", bus_req_o); end
        cyc(); mem_ce_i = 1'b0; smp();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin bad++; $display("FAIL load_idle got=%b%b exp=00", bus_req_o, stallreq_o); end
    endtask

    task automatic test_store();
        int nreq = 0;
        cyc(); set_req(1'b1, 32'h0000_0013, 4'b1000, 32'h5A5A_5A5A); smp();
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL st_stall got=%b exp=1", stallreq_o); end
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777; smp();
        total++; if (bus_addr_o !== 32'h0000_0010) begin bad++; $display("FAIL st_addr got=%h exp=00000010", bus_addr_o); end
        total++; if (bus_we_o !== 1'b1) begin bad++; $display("FAIL st_we got=%b exp=1", bus_we_o); end
        total++; if (bus_sel_o !== 4'b1000) begin bad++; $display("FAIL st_sel got=%b exp=1000", bus_sel_o); end
        total++; if (bus_wdata_o !== 32'h5A5A_5A5A) begin bad++; $display("FAIL st_wdata got=%h exp=5a5a5a5a", bus_wdata_o); end
        cyc(); bus_ack_i = 1'b0; smp();
        total++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin bad++; $display("FAIL st_done got=%b%b exp=00", stallreq_o, bus_req_o); end
        total++; if (mem_rdata_o !== 32'h0) begin bad++; $display("FAIL st_rdata got=%h exp=0", mem_rdata_o); end
        cyc(); mem_ce_i = 1'b0; mem_we_i = 1'b0;
        repeat (4) begin cyc(); smp(); nreq += int'(bus_req_o); end
        total++; if (nreq !== 0) begin bad++; $display("FAIL st_single got=%0d exp=0 extra req cycles", nreq); end
    endtask

    task automatic test_done_hold();
        int nreq = 0;
        cyc(); set_req(1'b0, 32'h0000_0100, 4'hF, 32'h0); smp(); nreq += int'(bus_req_o);
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678; smp(); nreq += int'(bus_req_o);
        cyc(); bus_rdata_i = 32'hFFFF_FFFF; mem_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            smp(); nreq += int'(bus_req_o);
            total++; if (mem_rdata_o !== 32'h1234_5678) begin bad++; $display("FAIL hold_rdata%0d got=%h exp=12345678", i, mem_rdata_o); end
            total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL hold_stall%0d got=%b exp=0", i, stallreq_o); end
        end
        cyc(); mem_stall_i = 1'b0; bus_ack_i = 1'b0; smp(); nreq += int'(bus_req_o);
        total++; if (mem_rdata_o !== 32'h1234_5678) begin bad++; $display("FAIL hold_rdata_end got=%h exp=12345678", mem_rdata_o); end
        cyc(); mem_ce_i = 1'b0; smp(); nreq += int'(bus_req_o);
        total++; if (nreq !== 1) begin bad++; $display("FAIL hold_bursts got=%0d exp=1 req cycles", nreq); end
    endtask

    task automatic test_timeout();
        int nreq = 0;
        int nerr = 0;
        cyc(); set_req(1'b0, 32'h0000_0200, 4'hF, 32'h0); bus_rdata_i = 32'hAAAA_5555; smp();
        for (int i = 0; i < 8; i++) begin
            cyc(); smp(); nreq += int'(bus_req_o); nerr += int'(bus_err_o);
        end
        total++; if (nreq !== 8) begin bad++; $display("FAIL to_req_cycles got=%0d exp=8", nreq); end
        total++; if (nerr !== 0) begin bad++; $display("FAIL to_err_early got=%0d exp=0", nerr); end
        cyc(); smp();
        total++; if (bus_err_o !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus_err_o); end
        total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b exp=0", bus_req_o); end
        total++; if (mem_rdata_o !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", mem_rdata_o); end
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL to_stall got=%b exp=0", stallreq_o); end
        cyc(); mem_ce_i = 1'b0; smp();
        total++; if (bus_err_o !== 1'b0 || bus_req_o !== 1'b0) begin bad++; $display("FAIL to_idle got=%b%b exp=00", bus_err_o, bus_req_o); end
    endtask

    task automatic test_flush_drain();
        cyc(); set_req(1'b0, 32'h0000_0300, 4'hF, 32'h0); bus_rdata_i = 32'h0; smp();
        cyc(); smp();
        total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL fd_req1 got=%b exp=1", bus_req_o); end
        cyc(); flush_i = 1'b1; smp();
        total++; if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1) begin bad++; $display("FAIL fd_req2 got=%b%b exp=11", bus_req_o, stallreq_o); end
        cyc(); flush_i = 1'b0; set_req(1'b0, 32'h0000_0400, 4'hF, 32'h0); smp();
        total++; if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1) begin bad++; $display("FAIL fd_drain got=%b%b exp=11", bus_req_o, stallreq_o); end
        total++; if (bus_addr_o !== 32'h0000_0300) begin bad++; $display("FAIL fd_drain_addr got=%h exp=00000300", bus_addr_o); end
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0; smp();
        total++; if (bus_req_o !== 1'b1 || stallreq_o !== 1'b1) begin bad++; $display("FAIL fd_drain_ack got=%b%b exp=11", bus_req_o, stallreq_o); end
        cyc(); bus_ack_i = 1'b0; smp();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b1) begin bad++; $display("FAIL fd_idle got=%b%b exp=01", bus_req_o, stallreq_o); end
        total++; if (mem_rdata_o !== 32'h0) begin bad++; $display("FAIL fd_discard got=%h exp=0", mem_rdata_o); end
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h0C0F_FEE0; smp();
        total++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0000_0400) begin bad++; $display("FAIL fd_second got=%b/%h exp=1/00000400", bus_req_o, bus_addr_o); end
        cyc(); bus_ack_i = 1'b0; smp();
        total++; if (mem_rdata_o !== 32'h0C0F_FEE0 || stallreq_o !== 1'b0) begin bad++; $display("FAIL fd_second_done got=%h/%b exp=0c0ffee0/0", mem_rdata_o, stallreq_o); end
        cyc(); mem_ce_i = 1'b0;
    endtask

    task automatic test_rst_in_req();
        cyc(); set_req(1'b0, 32'h0000_0500, 4'hF, 32'h0); smp();
        cyc(); smp();
        total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rr_req got=%b exp=1", bus_req_o); end
        rst = 1'b1;
        cyc(); rst = 1'b0; mem_ce_i = 1'b0; smp();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin bad++; $display("FAIL rr_drop got=%b%b exp=00", bus_req_o, stallreq_o); end
        total++; if (mem_rdata_o !== 32'h0 || bus_addr_o !== 32'h0) begin bad++; $display("FAIL rr_clear got=%h/%h exp=0/0", mem_rdata_o, bus_addr_o); end
        cyc(); set_req(1'b0, 32'h0000_0504, 4'hF, 32'h0); smp();
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL rr_accept got=%b exp=1", stallreq_o); end
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h600D_F00D; smp();
        total++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0000_0504) begin bad++; $display("FAIL rr_req2 got=%b/%h exp=1/00000504", bus_req_o, bus_addr_o); end
        cyc(); bus_ack_i = 1'b0; smp();
        total++; if (mem_rdata_o !== 32'h600D_F00D) begin bad++; $display("FAIL rr_rdata got=%h exp=600df00d", mem_rdata_o); end
        cyc(); mem_ce_i = 1'b0;
    endtask

    task automatic test_flush_cases();
        cyc(); set_req(1'b0, 32'h0000_0600, 4'hF, 32'h0); flush_i = 1'b1; smp();
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL fi_stall got=%b exp=0", stallreq_o); end
        cyc(); flush_i = 1'b0; mem_ce_i = 1'b0; smp();
        total++; if (bus_req_o !== 1'b0) begin bad++; $display("FAIL fi_req got=%b exp=0", bus_req_o); end
        cyc(); set_req(1'b0, 32'h0000_0604, 4'hF, 32'h0); smp();
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111; flush_i = 1'b1; smp();
        total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL fa_req got=%b exp=1", bus_req_o); end
        cyc(); bus_ack_i = 1'b0; flush_i = 1'b0; mem_ce_i = 1'b0; smp();
        total++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin bad++; $display("FAIL fa_idle got=%b%b exp=00", bus_req_o, stallreq_o); end
        total++; if (mem_rdata_o !== 32'h600D_F00D) begin bad++; $display("FAIL fa_discard got=%h exp=600df00d", mem_rdata_o); end
        cyc(); set_req(1'b0, 32'h0000_0608, 4'hF, 32'h0); smp();
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h2222_2222; smp();
        cyc(); bus_ack_i = 1'b0; mem_stall_i = 1'b1; flush_i = 1'b1; smp();
        total++; if (mem_rdata_o !== 32'h2222_2222) begin bad++; $display("FAIL fdn_rdata got=%h exp=22222222", mem_rdata_o); end
        cyc(); flush_i = 1'b0; mem_stall_i = 1'b0; set_req(1'b0, 32'h0000_060C, 4'hF, 32'h0); smp();
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL fdn_idle got=%b exp=1", stallreq_o); end
        cyc(); bus_ack_i = 1'b1; bus_rdata_i = 32'h3333_3333; smp();
        total++; if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0000_060C) begin bad++; $display("FAIL fdn_req got=%b/%h exp=1/0000060c", bus_req_o, bus_addr_o); end
        cyc(); bus_ack_i = 1'b0; smp();
        total++; if (mem_rdata_o !== 32'h3333_3333) begin bad++; $display("FAIL fdn_rdata2 got=%h exp=33333333", mem_rdata_o); end
        cyc(); mem_ce_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        mem_ce_i    = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h0;
        mem_sel_i   = 4'h0;
        mem_data_i  = 32'h0;
        mem_stall_i = 1'b0;
        flush_i     = 1'b0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        test_reset();
        test_load();
        test_store();
        test_done_hold();
        test_timeout();
        test_flush_drain();
        test_rst_in_req();
        test_flush_cases();
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
